// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider.
// master drives operands and the ctrl_DIV start pulse; slave returns
// quotient, remainder, divide-by-zero flag and the one-cycle ready pulse.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_DIV,
        input  data_result,
        input  data_remainder,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_DIV,
        output data_result,
        output data_remainder,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider, one quotient bit per cycle.
// Ports: clock, reset (sync, active-high), bus (seq_divider_if.slave):
//   operands A/B and ctrl_DIV start in; quotient, remainder,
//   divide-by-zero flag and one-cycle data_resultRDY pulse out.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q_q, sgn_q_d;
    logic             sgn_r_q, sgn_r_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        q_d      = q_q;
        b_d      = b_q;
        sgn_q_d  = sgn_q_q;
        sgn_r_d  = sgn_r_q;
        result_d = result_q;
        rem_d    = rem_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        abs_a = bus.data_operandA[WIDTH-1]
              ? (~bus.data_operandA) + WIDTH'(1)
              : bus.data_operandA;
        abs_b = bus.data_operandB[WIDTH-1]
              ? (~bus.data_operandB) + WIDTH'(1)
              : bus.data_operandB;

        // Shift in the next dividend bit, then trial-subtract |B|;
        // t[WIDTH] is the sign of the trial difference.
        p_sh = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        t    = p_sh + ~{1'b0, b_q} + (WIDTH+1)'(1);

        if (bus.ctrl_DIV) begin
            // A start edge in any state abandons the current divide.
            sgn_q_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            sgn_r_d = bus.data_operandA[WIDTH-1];
            q_d     = abs_a;
            b_d     = abs_b;
            p_d     = '0;
            cnt_d   = '0;
            exc_d   = 1'b0;
            state_d = (bus.data_operandB == '0) ? DONE : RUN;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                RUN: begin
                    if (!t[WIDTH]) begin
                        p_d = t;
                        q_d = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_d = p_sh;
                        q_d = {q_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // |B| is zero only when the divisor was zero.
                    if (b_q == '0) begin
                        exc_d    = 1'b1;
                        result_d = '0;
                        rem_d    = '0;
                    end else begin
                        result_d = sgn_q_q ? (~q_q) + WIDTH'(1) : q_q;
                        rem_d    = sgn_r_q ? (~p_q[WIDTH-1:0]) + WIDTH'(1)
                                           : p_q[WIDTH-1:0];
                    end
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            q_q      <= '0;
            b_q      <= '0;
            sgn_q_q  <= 1'b0;
            sgn_r_q  <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            q_q      <= q_d;
            b_q      <= b_d;
            sgn_q_q  <= sgn_q_d;
            sgn_r_q  <= sgn_r_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_remainder = rem_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
// Drives the interface master side; checks latency, values and hold.
module tb_seq_divider;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_DIV      = 1'b1;
        step();
        bus.ctrl_DIV      = 1'b0;
    endtask

    task automatic watch(input int n, output int first, output int pulses,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic e);
        first  = -1;
        pulses = 0;
        q      = '0;
        r      = '0;
        e      = 1'b0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (bus.data_resultRDY === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
                q = bus.data_result;
                r = bus.data_remainder;
                e = bus.data_exception;
            end
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq,
                       input logic [31:0] er, input logic ee,
                       input int lat);
        int          first, pulses;
        logic [31:0] q, r;
        logic        e;
        start(a, b);
        check({tag, "_exc_clr"}, {31'b0, bus.data_exception}, 32'd0);
        watch(40, first, pulses, q, r, e);
        check({tag, "_lat"}, first, lat);
        check({tag, "_pulses"}, pulses, 32'd1);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_e"}, {31'b0, e}, {31'b0, ee});
        check({tag, "_hold_q"}, bus.data_result, eq);
        check({tag, "_hold_e"}, {31'b0, bus.data_exception}, {31'b0, ee});
    endtask

    initial begin
        int          first, pulses;
        logic [31:0] q, r;
        logic        e;

        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_DIV      = 1'b0;
        step();
        step();
        check("rst_q", bus.data_result, 32'd0);
        check("rst_r", bus.data_remainder, 32'd0);
        check("rst_e", {31'b0, bus.data_exception}, 32'd0);
        check("rst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
        reset = 1'b0;
        step();

        run("p100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run("n100_7", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE,
            1'b0, 33);
        run("p100_n7", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,
            1'b0, 33);
        run("dbz", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1);
        run("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,
            1'b0, 33);
        run("small", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);

        // Restart at cycle 10 with new operands
        start(32'd100, 32'd7);
        watch(9, first, pulses, q, r, e);
        check("rs_early", pulses, 32'd0);
        start(32'd81, 32'd9);
        watch(40, first, pulses, q, r, e);
        check("rs_lat", first, 32'd33);
        check("rs_pulses", pulses, 32'd1);
        check("rs_q", q, 32'd9);
        check("rs_r", r, 32'd0);

        // Reset at cycle 15 aborts the divide
        start(32'd100, 32'd7);
        watch(14, first, pulses, q, r, e);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ab_q", bus.data_result, 32'd0);
        check("ab_r", bus.data_remainder, 32'd0);
        check("ab_e", {31'b0, bus.data_exception}, 32'd0);
        watch(40, first, pulses, q, r, e);
        check("ab_pulses", pulses, 32'd0);
        run("p50_5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

        // Reset and start on the same edge: reset wins
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        bus.ctrl_DIV      = 1'b1;
        reset             = 1'b1;
        step();
        bus.ctrl_DIV      = 1'b0;
        reset             = 1'b0;
        check("sim_q", bus.data_result, 32'd0);
        watch(40, first, pulses, q, r, e);
        check("sim_pulses", pulses, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
